// File: rtl/wt_dcache_shct_ctrl.sv
// SHCT controller: arbitrates the single table port between the init sweep, predictor lookups
// and queued hit/evict read-modify-write updates of saturating counters.
module wt_dcache_shct_ctrl #(
  parameter int SigWidth  = 14,
  parameter int CtrWidth  = 2,
  parameter int CtrInit   = 3,
  parameter int FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                init_busy_o,
  input  logic                lkp_req_i,
  input  logic [SigWidth-1:0] lkp_sig_i,
  output logic                lkp_gnt_o,
  output logic                lkp_rvalid_o,
  output logic [CtrWidth-1:0] lkp_ctr_o,
  input  logic                hit_upd_i,
  input  logic [SigWidth-1:0] hit_sig_i,
  input  logic                evc_upd_i,
  input  logic [SigWidth-1:0] evc_sig_i,
  input  logic                evc_reused_i,
  output logic                upd_full_o,
  output logic [15:0]         upd_drop_cnt_o,
  output logic                tbl_req_o,
  output logic                tbl_we_o,
  output logic [SigWidth-1:0] tbl_addr_o,
  output logic [CtrWidth-1:0] tbl_wdata_o,
  input  logic [CtrWidth-1:0] tbl_rdata_i
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {INIT, IDLE, RMW_WR} state_t;

  state_t              state_reg, state_next;
  logic [SigWidth-1:0] sweep_addr_reg;
  logic [SigWidth-1:0] fifo_sig [FifoDepth];
  logic                fifo_inc [FifoDepth];
  logic [PtrW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CntW-1:0]     count_reg;
  logic [15:0]         drop_cnt_reg;
  logic                rvalid_reg;

  logic                full, pop, upd_active;
  logic                hit_req, evc_req, hit_push, evc_push;
  logic [CntW-1:0]     free_slots;
  logic [1:0]          drops;
  logic [16:0]         drop_sum;
  logic [SigWidth-1:0] head_sig;
  logic                head_inc;
  logic [CtrWidth-1:0] sat_val;

  assign full     = (count_reg == CntW'(FifoDepth));
  assign head_sig = fifo_sig[rd_ptr_reg];
  assign head_inc = fifo_inc[rd_ptr_reg];

  always_comb begin
    sat_val = tbl_rdata_i;
    if (head_inc) begin
      if (tbl_rdata_i != {CtrWidth{1'b1}}) sat_val = tbl_rdata_i + CtrWidth'(1);
    end else begin
      if (tbl_rdata_i != '0) sat_val = tbl_rdata_i - CtrWidth'(1);
    end
  end

  // Pushes only count against slots free at the start of the cycle; a same-cycle pop frees nothing.
  assign upd_active = (state_reg != INIT) && !flush_i;
  assign hit_req    = hit_upd_i && upd_active;
  assign evc_req    = evc_upd_i && !evc_reused_i && upd_active;
  assign free_slots = CntW'(FifoDepth) - count_reg;
  assign hit_push   = hit_req && (free_slots != '0);
  assign evc_push   = evc_req && (free_slots > CntW'(hit_push));
  assign drops      = {1'b0, hit_req && !hit_push} + {1'b0, evc_req && !evc_push};
  assign drop_sum   = {1'b0, drop_cnt_reg} + 17'(drops);

  always_comb begin
    state_next  = state_reg;
    tbl_req_o   = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_addr_o  = '0;
    tbl_wdata_o = '0;
    lkp_gnt_o   = 1'b0;
    pop         = 1'b0;
    case (state_reg)
      INIT: begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = sweep_addr_reg;
        tbl_wdata_o = CtrWidth'(CtrInit);
        if (sweep_addr_reg == {SigWidth{1'b1}}) state_next = IDLE;
      end
      IDLE: begin
        if (full) begin
          tbl_req_o  = 1'b1;
          tbl_addr_o = head_sig;
          state_next = RMW_WR;
        end else if (lkp_req_i) begin
          tbl_req_o  = 1'b1;
          tbl_addr_o = lkp_sig_i;
          lkp_gnt_o  = 1'b1;
        end else if (count_reg != '0) begin
          tbl_req_o  = 1'b1;
          tbl_addr_o = head_sig;
          state_next = RMW_WR;
        end
      end
      RMW_WR: begin
        state_next = IDLE;
        if (!flush_i) begin
          tbl_req_o   = 1'b1;
          tbl_we_o    = 1'b1;
          tbl_addr_o  = head_sig;
          tbl_wdata_o = sat_val;
          pop         = 1'b1;
        end
      end
      default: state_next = INIT;
    endcase
    if (flush_i) state_next = INIT;
    // Nothing reaches the table while reset is held, including a pending RMW write.
    if (rst_i) begin
      tbl_req_o   = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = '0;
      tbl_wdata_o = '0;
      lkp_gnt_o   = 1'b0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= INIT;
      sweep_addr_reg <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_cnt_reg   <= '0;
      rvalid_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rvalid_reg <= lkp_gnt_o;
      if (flush_i) begin
        sweep_addr_reg <= '0;
        rd_ptr_reg     <= '0;
        wr_ptr_reg     <= '0;
        count_reg      <= '0;
      end else begin
        if (state_reg == INIT) sweep_addr_reg <= sweep_addr_reg + SigWidth'(1);
        rd_ptr_reg <= rd_ptr_reg + PtrW'(pop);
        wr_ptr_reg <= wr_ptr_reg + PtrW'(hit_push) + PtrW'(evc_push);
        count_reg  <= count_reg + CntW'(hit_push) + CntW'(evc_push) - CntW'(pop);
      end
      drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Hit is always queued ahead of a same-cycle evict.
  always_ff @(posedge clk_i) begin
    if (hit_push) begin
      fifo_sig[wr_ptr_reg] <= hit_sig_i;
      fifo_inc[wr_ptr_reg] <= 1'b1;
    end
    if (evc_push) begin
      fifo_sig[wr_ptr_reg + PtrW'(hit_push)] <= evc_sig_i;
      fifo_inc[wr_ptr_reg + PtrW'(hit_push)] <= 1'b0;
    end
  end

  assign init_busy_o    = (state_reg == INIT);
  assign lkp_rvalid_o   = rvalid_reg;
  assign lkp_ctr_o      = rvalid_reg ? tbl_rdata_i : '0;
  assign upd_full_o     = full;
  assign upd_drop_cnt_o = drop_cnt_reg;

endmodule
